// File: rtl/uart_hex_entry_ctrl_if.sv
// ============================================================================
// Module   : uart_hex_entry_ctrl_if
// Purpose  : UART byte input and display/entry status bundle for the hex-entry controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_hex_entry_ctrl_if;
  logic [7:0]  uart_data;
  logic        flag_complete;
  logic [15:0] data;
  logic [15:0] pending;
  logic [2:0]  digit_count;
  logic [7:0]  err_count;
  logic        commit;
  logic        timeout;

  modport master (
    output uart_data, flag_complete,
    input  data, pending, digit_count, err_count, commit, timeout
  );

  modport slave (
    input  uart_data, flag_complete,
    output data, pending, digit_count, err_count, commit, timeout
  );
endinterface

`default_nettype wire

// File: rtl/uart_hex_entry_ctrl.sv
// ============================================================================
// Module   : uart_hex_entry_ctrl
// Purpose  : ASCII hex-entry command decoder: assembles up to 4 digits, commits on CR
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_hex_entry_ctrl #(
  parameter logic [15:0] RESET_VALUE = 16'hAA00,
  parameter int          TIMEOUT     = 48_000_000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  uart_hex_entry_ctrl_if.slave bus
);

  localparam int                   c_TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
  localparam logic [7:0]           c_CR         = 8'h0D;
  localparam logic [7:0]           c_BS         = 8'h08;
  localparam logic [7:0]           c_ESC        = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_sync;
  logic [15:0]          r_data;
  logic [15:0]          r_pending;
  logic [2:0]           r_count;
  logic [7:0]           r_err;
  logic                 r_commit;
  logic                 r_timeout;
  logic [c_TIMER_W-1:0] r_timer;

  logic                 w_event;
  logic                 w_is_hex;
  logic [3:0]           w_nibble;

  // uart_data needs no synchroniser: it is held stable for the whole frame
  assign w_event = r_sync[1] & ~r_sync[2];

  always_comb begin
    w_is_hex = 1'b0;
    w_nibble = 4'd0;
    if (bus.uart_data >= 8'h30 && bus.uart_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nibble = bus.uart_data[3:0];
    end else if ((bus.uart_data >= 8'h41 && bus.uart_data <= 8'h46) ||
                 (bus.uart_data >= 8'h61 && bus.uart_data <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nibble = bus.uart_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync    <= 3'b000;
      r_data    <= RESET_VALUE;
      r_pending <= 16'h0000;
      r_count   <= 3'd0;
      r_err     <= 8'd0;
      r_commit  <= 1'b0;
      r_timeout <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_sync    <= {r_sync[1:0], bus.flag_complete};
      r_commit  <= 1'b0;
      r_timeout <= 1'b0;

      if (w_event) begin
        // A byte landing on the expiry cycle takes precedence over the timeout
        r_timer <= '0;
        if (w_is_hex) begin
          if (r_state == S_FULL) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end else begin
            r_pending <= {r_pending[11:0], w_nibble};
            r_count   <= r_count + 3'd1;
            r_state   <= (r_count == 3'd3) ? S_FULL : S_ENTRY;
          end
        end else begin
          case (bus.uart_data)
            c_CR: begin
              if (r_state != S_IDLE) begin
                r_data    <= r_pending;
                r_commit  <= 1'b1;
                r_pending <= 16'h0000;
                r_count   <= 3'd0;
                r_state   <= S_IDLE;
              end
            end
            c_BS: begin
              if (r_state != S_IDLE) begin
                r_pending <= r_pending >> 4;
                r_count   <= r_count - 3'd1;
                r_state   <= (r_count == 3'd1) ? S_IDLE : S_ENTRY;
              end
            end
            c_ESC: begin
              r_pending <= 16'h0000;
              r_count   <= 3'd0;
              r_state   <= S_IDLE;
            end
            default: begin
              if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            end
          endcase
        end
      end else if (r_state == S_IDLE) begin
        r_timer <= '0;
      end else if (r_timer == c_TIMER_LAST) begin
        r_timer   <= '0;
        r_pending <= 16'h0000;
        r_count   <= 3'd0;
        r_state   <= S_IDLE;
        r_timeout <= 1'b1;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign bus.data        = r_data;
  assign bus.pending     = r_pending;
  assign bus.digit_count = r_count;
  assign bus.err_count   = r_err;
  assign bus.commit      = r_commit;
  assign bus.timeout     = r_timeout;

endmodule

`default_nettype wire
